// File: rtl/video_stream_pkg.sv
// rtl/video_stream_pkg.sv - shared video stream constants, pixel type and capture states
package video_stream_pkg;

  localparam int IMG_WIDTH  = 320;
  localparam int IMG_LENGTH = 240;
  localparam int PIX_W      = 12;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    DISCARD
  } cap_state_t;

endpackage

// File: rtl/video_frame_capture.sv
// rtl/video_frame_capture.sv - Avalon-ST video sink writing frames into a double-buffered frame RAM
module video_frame_capture
  import video_stream_pkg::*;
#(
  parameter int IMG_WIDTH  = video_stream_pkg::IMG_WIDTH,
  parameter int IMG_LENGTH = video_stream_pkg::IMG_LENGTH,
  parameter int DATA_WIDTH = video_stream_pkg::PIX_W,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  startofpacket_in,
  input  logic                  endofpacket_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  mem_busy,
  output logic                  ready_out,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_bank,
  output logic                  rd_bank,
  output logic                  frame_done,
  output logic                  frame_error
);

  localparam int                  LEN_I = IMG_WIDTH * IMG_LENGTH;
  localparam logic [ADDR_WIDTH-1:0] LEN  = ADDR_WIDTH'(LEN_I);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LEN_I - 1);
  // State after the first pixel of a frame; a one-pixel frame is already full.
  localparam cap_state_t          AFTER_FIRST = (LEN_I == 1) ? DISCARD : RECEIVE;

  cap_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic                  r_frame_done;
  logic                  r_frame_error;
  logic                  w_accept;

  assign ready_out = !mem_busy && !reset;
  assign w_accept  = valid_in && ready_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_wr_bank     <= 1'b0;
      r_rd_bank     <= 1'b1;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_wr_en       <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
      if (w_accept) begin
        case (r_state)
          IDLE: begin
            if (startofpacket_in) begin
              if (endofpacket_in && LEN_I > 1) begin
                r_frame_error <= 1'b1;
              end else if (endofpacket_in) begin
                r_wr_en      <= 1'b1;
                r_wr_addr    <= '0;
                r_wr_data    <= data_in;
                r_frame_done <= 1'b1;
                r_rd_bank    <= r_wr_bank;
                r_wr_bank    <= ~r_wr_bank;
              end else begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= '0;
                r_wr_data <= data_in;
                r_cnt     <= ADDR_WIDTH'(1);
                r_state   <= AFTER_FIRST;
              end
            end
          end
          RECEIVE, DISCARD: begin
            if (startofpacket_in) begin
              // Abort the frame in progress and restart it in the same bank.
              r_frame_error <= 1'b1;
              if (endofpacket_in) begin
                r_cnt   <= '0;
                r_state <= IDLE;
              end else begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= '0;
                r_wr_data <= data_in;
                r_cnt     <= ADDR_WIDTH'(1);
                r_state   <= AFTER_FIRST;
              end
            end else if (r_state == DISCARD) begin
              if (endofpacket_in) begin
                r_frame_error <= 1'b1;
                r_cnt         <= '0;
                r_state       <= IDLE;
              end
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_cnt;
              r_wr_data <= data_in;
              if (endofpacket_in) begin
                if (r_cnt == LAST) begin
                  r_frame_done <= 1'b1;
                  r_rd_bank    <= r_wr_bank;
                  r_wr_bank    <= ~r_wr_bank;
                end else begin
                  r_frame_error <= 1'b1;
                end
                r_cnt   <= '0;
                r_state <= IDLE;
              end else if (r_cnt == LAST) begin
                r_cnt   <= LEN;
                r_state <= DISCARD;
              end else begin
                r_cnt <= r_cnt + ADDR_WIDTH'(1);
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign wr_bank     = r_wr_bank;
  assign rd_bank     = r_rd_bank;
  assign frame_done  = r_frame_done;
  assign frame_error = r_frame_error;

endmodule

// File: tb/tb_video_frame_capture.sv
// tb/tb_video_frame_capture.sv - directed self-checking bench for video_frame_capture
module tb_video_frame_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        startofpacket_in;
  logic        endofpacket_in;
  logic [11:0] data_in;
  logic        mem_busy;
  logic        ready_out;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_bank;
  logic        rd_bank;
  logic        frame_done;
  logic        frame_error;

  int checks   = 0;
  int failures = 0;

  logic [16:0] log_addr [256];
  logic [11:0] log_data [256];
  int          n_wr   = 0;
  int          n_done = 0;
  int          n_err  = 0;
  logic        done_wen;
  logic [16:0] done_addr;
  logic        err_wen;
  logic [16:0] err_addr;

  video_frame_capture #(
    .IMG_WIDTH (4),
    .IMG_LENGTH(2),
    .DATA_WIDTH(12),
    .ADDR_WIDTH(17)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .startofpacket_in(startofpacket_in),
    .endofpacket_in  (endofpacket_in),
    .data_in         (data_in),
    .mem_busy        (mem_busy),
    .ready_out       (ready_out),
    .wr_en           (wr_en),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_bank         (wr_bank),
    .rd_bank         (rd_bank),
    .frame_done      (frame_done),
    .frame_error     (frame_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en && n_wr < 256) begin
        log_addr[n_wr] = wr_addr;
        log_data[n_wr] = wr_data;
        n_wr++;
      end
      if (frame_done) begin
        n_done++;
        done_wen  = wr_en;
        done_addr = wr_addr;
      end
      if (frame_error) begin
        n_err++;
        err_wen  = wr_en;
        err_addr = wr_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_in         = 1'b0;
    startofpacket_in = 1'b0;
    endofpacket_in   = 1'b0;
    data_in          = '0;
    mem_busy         = 1'b0;
  endtask

  task automatic beat(input logic sop, input logic eop, input int d);
    valid_in         = 1'b1;
    startofpacket_in = sop;
    endofpacket_in   = eop;
    data_in          = 12'(d);
    mem_busy         = 1'b0;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic good_frame();
    for (int i = 0; i < 8; i++) beat(i == 0, i == 7, i);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_seq(input string tag, input int base);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_addr"}, 32'(log_addr[base+i]), 32'(i));
      chk({tag, "_data"}, 32'(log_data[base+i]), 32'(i));
    end
  endtask

  int w0, d0, e0;

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready_out, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 1);
    chk("rst_done", frame_done, 0);
    chk("rst_error", frame_error, 0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", ready_out, 1);

    // good frame
    w0 = n_wr; d0 = n_done; e0 = n_err;
    good_frame();
    settle();
    chk("good_nwr", n_wr - w0, 8);
    chk_seq("good", w0);
    chk("good_done", n_done - d0, 1);
    chk("good_err", n_err - e0, 0);
    chk("good_done_wen", done_wen, 1);
    chk("good_done_addr", done_addr, 7);
    chk("good_rd_bank", rd_bank, 0);
    chk("good_wr_bank", wr_bank, 1);

    // backpressure and valid gaps
    w0 = n_wr; d0 = n_done; e0 = n_err;
    begin
      int k;
      int b;
      logic busy;
      logic v;
      k = 0;
      b = 0;
      while (b < 8 && k < 100) begin
        busy             = (k % 3 == 2);
        v                = (k % 4 != 3);
        valid_in         = v;
        startofpacket_in = (b == 0);
        endofpacket_in   = (b == 7);
        data_in          = 12'(b);
        mem_busy         = busy;
        #1;
        chk("bp_ready", ready_out, !busy);
        @(posedge clk);
        #1;
        if (v && !busy) b++;
        k++;
      end
      idle_inputs();
      chk("bp_beats", b, 8);
    end
    settle();
    chk("bp_nwr", n_wr - w0, 8);
    chk_seq("bp", w0);
    chk("bp_done", n_done - d0, 1);
    chk("bp_err", n_err - e0, 0);
    chk("bp_rd_bank", rd_bank, 1);
    chk("bp_wr_bank", wr_bank, 0);

    // short frame
    w0 = n_wr; d0 = n_done; e0 = n_err;
    for (int i = 0; i < 6; i++) beat(i == 0, i == 5, i);
    settle();
    chk("short_nwr", n_wr - w0, 6);
    chk("short_last_addr", log_addr[w0+5], 5);
    chk("short_err", n_err - e0, 1);
    chk("short_err_wen", err_wen, 1);
    chk("short_err_addr", err_addr, 5);
    chk("short_done", n_done - d0, 0);
    chk("short_rd_bank", rd_bank, 1);
    chk("short_wr_bank", wr_bank, 0);

    // SOP-less beats then long frame
    w0 = n_wr; d0 = n_done; e0 = n_err;
    for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, i);
    settle();
    chk("nosop_nwr", n_wr - w0, 0);
    for (int i = 0; i < 10; i++) beat(i == 0, i == 9, i);
    settle();
    chk("long_nwr", n_wr - w0, 8);
    chk_seq("long", w0);
    chk("long_err", n_err - e0, 1);
    chk("long_err_wen", err_wen, 0);
    chk("long_done", n_done - d0, 0);
    chk("long_rd_bank", rd_bank, 1);
    chk("long_wr_bank", wr_bank, 0);

    // mid-frame SOP restart
    w0 = n_wr; d0 = n_done; e0 = n_err;
    for (int i = 0; i < 3; i++) beat(i == 0, 1'b0, i);
    beat(1'b1, 1'b0, 0);
    settle();
    chk("restart_err", n_err - e0, 1);
    chk("restart_err_wen", err_wen, 1);
    chk("restart_err_addr", err_addr, 0);
    for (int i = 1; i < 8; i++) beat(1'b0, i == 7, i);
    settle();
    chk("restart_nwr", n_wr - w0, 11);
    chk_seq("restart", w0 + 3);
    chk("restart_done", n_done - d0, 1);
    chk("restart_err_total", n_err - e0, 1);
    chk("restart_rd_bank", rd_bank, 0);
    chk("restart_wr_bank", wr_bank, 1);

    // reset mid-frame
    e0 = n_err;
    for (int i = 0; i < 5; i++) beat(i == 0, 1'b0, i);
    chk("pre_rst_wen", wr_en, 1);
    reset = 1'b1;
    #1;
    chk("arst_ready", ready_out, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_wr_bank", wr_bank, 0);
    chk("arst_rd_bank", rd_bank, 1);
    chk("arst_error", frame_error, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("arst_no_err", n_err - e0, 0);
    w0 = n_wr; d0 = n_done;
    good_frame();
    settle();
    chk("post_rst_nwr", n_wr - w0, 8);
    chk_seq("post_rst", w0);
    chk("post_rst_done", n_done - d0, 1);
    chk("post_rst_err", n_err - e0, 0);
    chk("post_rst_rd_bank", rd_bank, 0);
    chk("post_rst_wr_bank", wr_bank, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
